// File: rtl/arb.sv
// Shared arbitration types for the memory-side muxes of the RV32I core.
package arb;

  typedef enum logic [1:0] {
    IDLE,
    I_SERVE,
    D_SERVE,
    RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pmem_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between the icache and dcache miss ports and the
// single physical-memory line port. One line transaction is in flight at a
// time; the granted request is latched so the memory sees stable strobes,
// address and write data regardless of what the requesters do meanwhile.
module cache_arbiter
  import arb::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  grant_t            r_last_grant;
  pmem_op_t          r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

  // Next-state and grant decision; ties go to the side not served last.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
          if (r_last_grant == GRANT_I) w_grant_d = 1'b1;
          else                         w_grant_i = 1'b1;
        end else if (w_i_req) begin
          w_grant_i = 1'b1;
        end else if (w_d_req) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_i) w_next_state = I_SERVE;
        if (w_grant_d) w_next_state = D_SERVE;
      end
      I_SERVE, D_SERVE: begin
        if (pmem_resp) w_next_state = RESP;
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Latch bank: grant-time capture of the request, response-time capture of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GRANT_I;
      r_op         <= OP_READ;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (w_grant_i) begin
        r_last_grant <= GRANT_I;
        r_op         <= OP_READ;
        r_addr       <= i_pmem_address;
      end
      if (w_grant_d) begin
        r_last_grant <= GRANT_D;
        r_op         <= d_pmem_write ? OP_WRITE : OP_READ;
        r_addr       <= d_pmem_address;
        r_wdata      <= d_pmem_wdata;
      end
      if (r_state == I_SERVE && pmem_resp) r_i_rdata <= pmem_rdata;
      if (r_state == D_SERVE && pmem_resp) r_d_rdata <= pmem_rdata;
    end
  end

  // Write wins when a misbehaving dcache raises both read and write.
  assign pmem_read    = (r_state == I_SERVE) || (r_state == D_SERVE && r_op == OP_READ);
  assign pmem_write   = (r_state == D_SERVE) && (r_op == OP_WRITE);
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign i_pmem_rdata = r_i_rdata;
  assign d_pmem_rdata = r_d_rdata;
  assign i_pmem_resp  = (r_state == RESP) && (r_last_grant == GRANT_I);
  assign d_pmem_resp  = (r_state == RESP) && (r_last_grant == GRANT_D);
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios followed by a
// randomized request mix, all judged against a transaction-level model that
// only knows who should be granted, what the memory should see and what
// each cache should get back.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              busy;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: who was served last (1 = dcache) and what each cache last received.
  bit                modelLastD;
  logic [LINE_W-1:0] modelIRdata;
  logic [LINE_W-1:0] modelDRdata;
  bit                iPending;
  bit                dPending;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .busy           (busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hang guard in case the DUT or a wait loop never settles.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                             input logic [LINE_W-1:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic logic [LINE_W-1:0] randLine();
    logic [LINE_W-1:0] v;
    for (int j = 0; j < LINE_W / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Rule: a lone requester wins; on a tie the side not served last wins.
  function automatic bit predictGrantD();
    if (iPending && dPending) return !modelLastD;
    return dPending;
  endfunction

  task automatic applyStimulus(input bit setI, input logic [ADDR_W-1:0] iAddr,
                               input bit setD, input bit dRd, input bit dWr,
                               input logic [ADDR_W-1:0] dAddr, input logic [LINE_W-1:0] dWdata);
    if (setI) begin
      i_pmem_read    = 1'b1;
      i_pmem_address = iAddr;
      iPending       = 1'b1;
    end
    if (setD) begin
      d_pmem_read    = dRd;
      d_pmem_write   = dWr;
      d_pmem_address = dAddr;
      d_pmem_wdata   = dWdata;
      dPending       = 1'b1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pmemRead"},  pmem_read,    '0);
    checkOutput({tag, "_pmemWrite"}, pmem_write,   '0);
    checkOutput({tag, "_pmemAddr"},  pmem_address, '0);
    checkOutput({tag, "_pmemWdata"}, pmem_wdata,   '0);
    checkOutput({tag, "_iRdata"},    i_pmem_rdata, '0);
    checkOutput({tag, "_dRdata"},    d_pmem_rdata, '0);
    checkOutput({tag, "_iResp"},     i_pmem_resp,  '0);
    checkOutput({tag, "_dResp"},     d_pmem_resp,  '0);
    checkOutput({tag, "_busy"},      busy,         '0);
  endtask

  task automatic resetModel();
    modelLastD  = 1'b0;
    modelIRdata = '0;
    modelDRdata = '0;
    iPending    = 1'b0;
    dPending    = 1'b0;
  endtask

  // Reset with all requests dropped; returns #1 after a clock edge with reset released.
  task automatic applyReset(input string tag);
    rst_n          = 1'b0;
    i_pmem_read    = 1'b0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    pmem_resp      = 1'b0;
    resetModel();
    #1;
    checkAllZero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One complete memory transaction as seen from the memory side. Called at a
  // point where the arbiter is idle and will sample requests on the next edge.
  task automatic runTxn(input bit expD, input int lat, input logic [LINE_W-1:0] data,
                        input bit reReq, input bit wiggle);
    int                waits = 0;
    bit                seen  = 0;
    bit                expWrite;
    logic [ADDR_W-1:0] expAddr;
    logic [LINE_W-1:0] expWdata;
    expAddr  = expD ? d_pmem_address : i_pmem_address;
    expWrite = expD && d_pmem_write;
    expWdata = d_pmem_wdata;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk);
      #1;
      waits++;
      if (pmem_read || pmem_write) seen = 1;
    end
    checkOutput("grantLatency", waits, 1);
    if (!seen) return;
    checkOutput("strobeRead",  pmem_read,    !expWrite);
    checkOutput("strobeWrite", pmem_write,   expWrite);
    checkOutput("grantAddr",   pmem_address, expAddr);
    checkOutput("serveBusy",   busy,         1);
    if (expWrite) checkOutput("grantWdata", pmem_wdata, expWdata);
    if (wiggle) begin
      if (expD) d_pmem_address = 32'h0000_0400;
      else      i_pmem_address = 32'h0000_0400;
    end
    for (int k = 0; k < lat; k++) begin
      @(posedge clk);
      #1;
      checkOutput("strobeHeld",  pmem_read | pmem_write,   1);
      checkOutput("addrHeld",    pmem_address,             expAddr);
      checkOutput("noEarlyResp", i_pmem_resp | d_pmem_resp, 0);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = randLine();
    if (expD) modelDRdata = data;
    else      modelIRdata = data;
    modelLastD = expD;
    checkOutput("strobeDropped", pmem_read | pmem_write, 0);
    checkOutput("iResp",         i_pmem_resp,  !expD);
    checkOutput("dResp",         d_pmem_resp,  expD);
    checkOutput("iRdata",        i_pmem_rdata, modelIRdata);
    checkOutput("dRdata",        d_pmem_rdata, modelDRdata);
    checkOutput("respBusy",      busy,         1);
    if (!reReq) begin
      if (expD) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        dPending     = 1'b0;
      end else begin
        i_pmem_read = 1'b0;
        iPending    = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("respOneCycle", i_pmem_resp | d_pmem_resp, 0);
    checkOutput("idleBusy",     busy,                      0);
    checkOutput("idleStrobe",   pmem_read | pmem_write,    0);
  endtask

  initial begin
    logic [LINE_W-1:0] lineA5;
    logic [LINE_W-1:0] lineDead;
    logic [7:0]        byteA5;
    logic [31:0]       wordDead;
    bit                doI;
    bit                doD;
    int                kind;
    byteA5   = 8'hA5;
    wordDead = 32'hDEAD_BEEF;
    lineA5   = {32{byteA5}};
    lineDead = {8{wordDead}};

    rst_n          = 1'b1;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
    resetModel();
    #2;
    applyReset("reset");

    $display("[TB] I read alone");
    applyStimulus(1, 32'h0000_0060, 0, 0, 0, '0, '0);
    runTxn(predictGrantD(), 3, lineA5, 0, 0);

    $display("[TB] tie after reset");
    applyReset("reset2");
    applyStimulus(1, 32'h0000_0100, 1, 1, 0, 32'h0000_0200, '0);
    runTxn(predictGrantD(), 1, randLine(), 0, 0);
    runTxn(predictGrantD(), 0, randLine(), 0, 0);

    $display("[TB] round-robin");
    applyStimulus(1, 32'h0000_1000, 1, 1, 0, 32'h0000_2000, '0);
    for (int n = 0; n < 4; n++) runTxn(predictGrantD(), 1, randLine(), 1, 0);
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    iPending    = 1'b0;
    dPending    = 1'b0;

    $display("[TB] D write-back");
    applyStimulus(0, '0, 1, 0, 1, 32'h0000_0080, lineDead);
    runTxn(predictGrantD(), 2, randLine(), 0, 0);

    $display("[TB] input instability");
    applyStimulus(1, 32'h0000_0300, 0, 0, 0, '0, '0);
    runTxn(predictGrantD(), 3, randLine(), 0, 1);

    $display("[TB] stray memory response while idle");
    pmem_resp  = 1'b1;
    pmem_rdata = randLine();
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    checkOutput("strayBusy",   busy,                      0);
    checkOutput("strayResp",   i_pmem_resp | d_pmem_resp, 0);
    checkOutput("strayIRdata", i_pmem_rdata,              modelIRdata);
    checkOutput("strayDRdata", d_pmem_rdata,              modelDRdata);

    $display("[TB] reset mid-transaction");
    applyStimulus(0, '0, 1, 1, 0, 32'h0000_0500, '0);
    @(posedge clk);
    #1;
    checkOutput("midStrobe", pmem_read, 1);
    rst_n     = 1'b0;
    pmem_resp = 1'b1;
    #1;
    checkAllZero("midReset");
    @(posedge clk);
    #1;
    checkOutput("midResetNoResp", d_pmem_resp, 0);
    checkOutput("midResetBusy",   busy,        0);
    pmem_resp = 1'b0;
    rst_n     = 1'b1;
    resetModel();
    applyStimulus(1, 32'h0000_0600, 1, 1, 0, 32'h0000_0700, '0);
    runTxn(predictGrantD(), 1, randLine(), 0, 0);
    runTxn(predictGrantD(), 2, randLine(), 0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 24; n++) begin
      doI = !iPending && ($urandom_range(0, 1) == 1);
      doD = !dPending && ($urandom_range(0, 1) == 1);
      if (!doI && !doD && !iPending && !dPending) doI = 1;
      kind = $urandom_range(0, 4);
      applyStimulus(doI, $urandom & 32'hFFFF_FFE0,
                    doD, (kind < 2) || (kind == 4), kind >= 2,
                    $urandom & 32'hFFFF_FFE0, randLine());
      runTxn(predictGrantD(), $urandom_range(0, 4), randLine(), 0, 0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbiter between the instruction cache and data cache miss ports and the single shared physical-memory line port of the pipelined RV32I core. It accepts at most one line transaction at a time and latches the granted requester's address and write data. It drives the memory port from registers and returns the memory response and read line to the granted cache. Ties are broken round-robin so that neither fetch nor load/store traffic can starve.

## Interface
- ADDR_W, 32, physical address width
- LINE_W, 256, cache line width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_pmem_read  in  1  icache line read request; held until i_pmem_resp
- i_pmem_address  in  ADDR_W  icache line address
- i_pmem_rdata  out  LINE_W  line returned to icache
- i_pmem_resp  out  1  one-cycle completion pulse to icache
- d_pmem_read  in  1  dcache line read request; held until d_pmem_resp
- d_pmem_write  in  1  dcache line write-back request; held until d_pmem_resp
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  write-back line
- d_pmem_rdata  out  LINE_W  line returned to dcache
- d_pmem_resp  out  1  one-cycle completion pulse to dcache
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_address  out  ADDR_W  latched transaction address
- pmem_wdata  out  LINE_W  latched write line
- pmem_rdata  in  LINE_W  memory read line, valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, I_SERVE, D_SERVE, RESP. Register last_grant ∈ {GRANT_I, GRANT_D}.
- IDLE: only I requests → I_SERVE. Only D requests (read or write) → D_SERVE. Both request → grant the side not equal to last_grant. Neither → stay in IDLE.
- On grant:
  - Latch address, and for D also wdata and the operation.
  - Update last_grant.
  - The op latch sets pmem_read or pmem_write, never both.
- d_pmem_read and d_pmem_write both high is a protocol violation. Write wins.
- I_SERVE/D_SERVE: the memory strobe and pmem_address/pmem_wdata stay constant from latches. Requester input changes are ignored. On pmem_resp:
  - capture pmem_rdata into the granted side's rdata register;
  - deassert the strobe;
  - → RESP.
- RESP: the granted side's *_pmem_resp is high for exactly this cycle, then → IDLE. Requests are not sampled in RESP.
- Requesters deassert the request in the cycle after the resp pulse. The arbiter relies on this and does not re-grant a held request until IDLE.
- *_pmem_rdata hold their last captured value until overwritten. The non-granted side's rdata never changes.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, last_grant = GRANT_I, so the first tie goes to D;
  - all outputs 0, including rdata registers, pmem_address and pmem_wdata.
- Request high at edge N in IDLE → strobe and address valid from cycle N+1.
- pmem_resp high at edge M:
  - strobe low from M+1;
  - requester resp high during cycle M+1 only;
  - IDLE at M+2;
  - next grant sampled at edge M+2, so next strobe at M+3.
- Minimum request-to-resp latency is 2 cycles, with a zero-wait memory answering in the first strobe cycle.
- pmem_resp outside I_SERVE/D_SERVE is ignored.
- Reset mid-transaction abandons it. No resp is issued, and the memory model must also be reset.

## Structure
- Shared package arb (alongside the mux select packages) holds:
  - arb_state_t enum {IDLE, I_SERVE, D_SERVE, RESP};
  - grant_t enum {GRANT_I, GRANT_D};
  - pmem_op_t enum {OP_READ, OP_WRITE}.
- Single module with no sub-module: state register, latch bank, next-state logic.

## Test plan
- **I read alone:** i_pmem_read, address 0x0000_0060; memory resp 3 cycles after strobe with rdata 0xA5 repeated.
  - Required: pmem_read from the next cycle with pmem_address 0x60.
  - Required: i_pmem_resp is one cycle and i_pmem_rdata is all-0xA5.
  - Required: d_pmem_resp stays 0.
- **Tie after reset:** I read 0x100 and D read 0x200 asserted in the same cycle.
  - Required: 0x200 is served first, then 0x100, with exactly one RESP and one IDLE cycle between strobes.
- **Round-robin:** both sides re-request immediately after each resp for 4 transactions.
  - Required: grant order D, I, D, I.
- **D write-back:** d_pmem_write, address 0x80, wdata 0xDEADBEEF repeated.
  - Required: pmem_write high and pmem_read low, pmem_wdata matches.
  - Required: d_pmem_resp pulses once; i side is untouched.
- **Input instability:** change i_pmem_address to 0x400 mid-I_SERVE.
  - Required: pmem_address holds the originally latched value until the strobe drops.
- **Reset mid-transaction:** drive rst_n low during D_SERVE.
  - Required: all outputs 0 in the same cycle, with no d_pmem_resp.
  - Required: after release, with both requesting, D is granted first.
